// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the datapath.
// The controller takes the master modport; the datapath takes the slave modport.
interface multicycle_controller_if;
  logic [6:0]  op;
  logic        zero;
  logic [2:0]  imm_src;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic [1:0]  result_src;
  logic        adr_src;
  logic        ir_write;
  logic        pc_write;
  logic        reg_write;
  logic        mem_write;
  logic        illegal_op;
  logic        instr_done;
  logic [31:0] instret;
  logic [3:0]  state;

  modport master (
    input  op, zero,
    output imm_src, alu_src_a, alu_src_b, alu_op, result_src, adr_src,
           ir_write, pc_write, reg_write, mem_write, illegal_op, instr_done,
           instret, state
  );

  modport slave (
    output op, zero,
    input  imm_src, alu_src_a, alu_src_b, alu_op, result_src, adr_src,
           ir_write, pc_write, reg_write, mem_write, illegal_op, instr_done,
           instret, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: Moore decode of state into datapath selects and write
// strobes, plus a retired-instruction counter.
module multicycle_controller (
  input  logic                    clk,
  input  logic                    rst,
  multicycle_controller_if.master ctrl
);

  localparam logic [6:0] OpLw  = 7'b0000011;
  localparam logic [6:0] OpSw  = 7'b0100011;
  localparam logic [6:0] OpR   = 7'b0110011;
  localparam logic [6:0] OpI   = 7'b0010011;
  localparam logic [6:0] OpBeq = 7'b1100011;
  localparam logic [6:0] OpJal = 7'b1101111;
  localparam logic [6:0] OpLui = 7'b0110111;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StAluWb    = 4'd7,
    StExecI    = 4'd8,
    StJal      = 4'd9,
    StBeq      = 4'd10,
    StLui      = 4'd11
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] instret_q, instret_d;

  logic op_legal;
  logic ir_write, pc_update, branch, reg_write, mem_write;
  logic illegal, done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFetch;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    op_legal = 1'b0;
    case (ctrl.op)
      OpLw, OpSw, OpR, OpI, OpBeq, OpJal, OpLui: op_legal = 1'b1;
      default:                                   op_legal = 1'b0;
    endcase
  end

  // Extend-unit select depends only on the opcode, independent of state.
  always_comb begin
    ctrl.imm_src = 3'b000;
    case (ctrl.op)
      OpSw:    ctrl.imm_src = 3'b001;
      OpBeq:   ctrl.imm_src = 3'b010;
      OpLui:   ctrl.imm_src = 3'b011;
      OpJal:   ctrl.imm_src = 3'b100;
      default: ctrl.imm_src = 3'b000;
    endcase
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        case (ctrl.op)
          OpLw, OpSw: state_d = StMemAdr;
          OpR:        state_d = StExecR;
          OpI:        state_d = StExecI;
          OpJal:      state_d = StJal;
          OpBeq:      state_d = StBeq;
          OpLui:      state_d = StLui;
          default:    state_d = StFetch;
        endcase
      end
      StMemAdr:  state_d = (ctrl.op == OpLw) ? StMemRead : StMemWrite;
      StMemRead: state_d = StMemWb;
      StExecR, StExecI, StJal: state_d = StAluWb;
      // Covers last states and the unused encodings 12-15.
      default:   state_d = StFetch;
    endcase
  end

  always_comb begin
    ctrl.alu_src_a  = 2'b00;
    ctrl.alu_src_b  = 2'b00;
    ctrl.alu_op     = 2'b00;
    ctrl.result_src = 2'b00;
    ctrl.adr_src    = 1'b0;
    ir_write        = 1'b0;
    pc_update       = 1'b0;
    branch          = 1'b0;
    reg_write       = 1'b0;
    mem_write       = 1'b0;
    done            = 1'b0;
    case (state_q)
      StFetch: begin
        ir_write        = 1'b1;
        ctrl.alu_src_b  = 2'b10;
        ctrl.result_src = 2'b10;
        pc_update       = 1'b1;
      end
      StDecode: begin
        ctrl.alu_src_a = 2'b01;
        ctrl.alu_src_b = 2'b01;
      end
      StMemAdr: begin
        ctrl.alu_src_a = 2'b10;
        ctrl.alu_src_b = 2'b01;
      end
      StMemRead: begin
        ctrl.adr_src = 1'b1;
      end
      StMemWrite: begin
        ctrl.adr_src = 1'b1;
        mem_write    = 1'b1;
        done         = 1'b1;
      end
      StMemWb: begin
        ctrl.result_src = 2'b01;
        reg_write       = 1'b1;
        done            = 1'b1;
      end
      StExecR: begin
        ctrl.alu_src_a = 2'b10;
        ctrl.alu_op    = 2'b10;
      end
      StExecI: begin
        ctrl.alu_src_a = 2'b10;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = 2'b10;
      end
      StAluWb: begin
        reg_write = 1'b1;
        done      = 1'b1;
      end
      StJal: begin
        ctrl.alu_src_a = 2'b01;
        ctrl.alu_src_b = 2'b10;
        pc_update      = 1'b1;
      end
      StBeq: begin
        ctrl.alu_src_a = 2'b10;
        ctrl.alu_op    = 2'b01;
        branch         = 1'b1;
        done           = 1'b1;
      end
      StLui: begin
        ctrl.result_src = 2'b11;
        reg_write       = 1'b1;
        done            = 1'b1;
      end
      default: ;
    endcase
    illegal = (state_q == StDecode) && !op_legal;
    if (illegal) done = 1'b1;
  end

  // Strobes are masked combinationally so nothing fires while reset is held.
  always_comb begin
    ctrl.ir_write   = ir_write & ~rst;
    ctrl.pc_write   = (pc_update | (branch & ctrl.zero)) & ~rst;
    ctrl.reg_write  = reg_write & ~rst;
    ctrl.mem_write  = mem_write & ~rst;
    ctrl.illegal_op = illegal & ~rst;
    ctrl.instr_done = done & ~rst;
  end

  always_comb begin
    instret_d = instret_q;
    if (done) instret_d = instret_q + 32'd1;
  end

  assign ctrl.instret = instret_q;
  assign ctrl.state   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: each instruction is checked cycle by cycle
// against per-opcode state paths and the per-state output table.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_instret;

  typedef int path_t[$];

  typedef struct packed {
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] alu_op;
    logic [1:0] res;
    logic       adr;
    logic       irw;
    logic       pcu;
    logic       br;
    logic       rw;
    logic       mw;
  } ctl_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                      7'b1100011, 7'b1101111, 7'b0110111};
  endfunction

  // Sequence of states visited by one instruction, starting at FETCH.
  function automatic path_t path(input logic [6:0] op);
    case (op)
      7'b0000011: return '{0, 1, 2, 3, 4};
      7'b0100011: return '{0, 1, 2, 5};
      7'b0110011: return '{0, 1, 6, 7};
      7'b0010011: return '{0, 1, 8, 7};
      7'b1101111: return '{0, 1, 9, 7};
      7'b1100011: return '{0, 1, 10};
      7'b0110111: return '{0, 1, 11};
      default:    return '{0, 1};
    endcase
  endfunction

  function automatic logic [2:0] exp_imm(input logic [6:0] op);
    case (op)
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b0110111: return 3'b011;
      7'b1101111: return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

  function automatic ctl_t spec_ctl(input int s);
    ctl_t c = '0;
    case (s)
      0:  begin c.irw = 1; c.src_b = 2'b10; c.res = 2'b10; c.pcu = 1; end
      1:  begin c.src_a = 2'b01; c.src_b = 2'b01; end
      2:  begin c.src_a = 2'b10; c.src_b = 2'b01; end
      3:  begin c.adr = 1; end
      4:  begin c.res = 2'b01; c.rw = 1; end
      5:  begin c.adr = 1; c.mw = 1; end
      6:  begin c.src_a = 2'b10; c.alu_op = 2'b10; end
      7:  begin c.rw = 1; end
      8:  begin c.src_a = 2'b10; c.src_b = 2'b01; c.alu_op = 2'b10; end
      9:  begin c.src_a = 2'b01; c.src_b = 2'b10; c.pcu = 1; end
      10: begin c.src_a = 2'b10; c.alu_op = 2'b01; c.br = 1; end
      11: begin c.res = 2'b11; c.rw = 1; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic [5:0] dut_strobes();
    return {bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_write,
            bus.illegal_op, bus.instr_done};
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, ".state"}, 32'(bus.state), 32'd0);
    check({tag, ".strobes"}, 32'(dut_strobes()), 32'd0);
    check({tag, ".instret"}, bus.instret, 32'd0);
  endtask

  // Entered and left on a falling edge. zmode: 0/1 fixed zero, 2 random.
  // rst_at >= 0 asserts reset at that step of the path and abandons the instruction.
  task automatic run_instr(input logic [6:0] op, input int zmode, input int rst_at);
    path_t       p;
    ctl_t        c;
    logic        z;
    logic        ill;
    logic        dn;
    logic [5:0]  exp_str;
    p      = path(op);
    bus.op = op;
    for (int i = 0; i < p.size(); i++) begin
      z        = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      bus.zero = z;
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        check_reset_state("rst_mid");
        exp_instret = '0;
        @(negedge clk);
        check_reset_state("rst_hold");
        rst = 1'b0;
        return;
      end
      #1;
      c       = spec_ctl(p[i]);
      ill     = (p[i] == 1) && !is_legal(op);
      dn      = (p[i] inside {4, 5, 7, 10, 11}) || ill;
      exp_str = {c.irw, c.pcu | (c.br & z), c.rw, c.mw, ill, dn};
      check("state", 32'(bus.state), 32'(p[i]));
      check("imm_src", 32'(bus.imm_src), 32'(exp_imm(op)));
      check("muxes", 32'({bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.result_src,
                          bus.adr_src}),
            32'({c.src_a, c.src_b, c.alu_op, c.res, c.adr}));
      check("strobes", 32'(dut_strobes()), 32'(exp_str));
      check("instret", bus.instret, exp_instret);
      if (dn) exp_instret = exp_instret + 32'd1;
      @(negedge clk);
    end
  endtask

  localparam logic [6:0] LegalOps [7] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                          7'b1100011, 7'b1101111, 7'b0110111};

  initial begin
    logic [6:0] op;
    int         len;
    int         ra;
    rst         = 1'b1;
    bus.op      = 7'b0000011;
    bus.zero    = 1'b0;
    exp_instret = '0;
    @(negedge clk);
    check_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;

    // Directed: lw, beq taken/not taken, sw, jal, illegal, reset inside lw MEMREAD.
    run_instr(7'b0000011, 2, -1);
    run_instr(7'b1100011, 1, -1);
    run_instr(7'b1100011, 0, -1);
    run_instr(7'b0100011, 2, -1);
    run_instr(7'b1101111, 2, -1);
    run_instr(7'b1111111, 2, -1);
    run_instr(7'b0000011, 2, 3);
    run_instr(7'b0110011, 2, -1);

    // Counter wrap on a retiring lui.
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    exp_instret = 32'hFFFF_FFFF;
    run_instr(7'b0110111, 2, -1);
    run_instr(7'b0010011, 2, -1);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 8) < 7) op = LegalOps[$urandom_range(0, 6)];
      else                          op = 7'($urandom);
      len = path(op).size();
      ra  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, len - 1)) : -1;
      run_instr(op, 2, ra);
    end

    #1;
    check("final_instret", bus.instret, exp_instret);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameters: none; opcode and state encodings are fixed by this document.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 op  input  7  instr[6:0] from the instruction register.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 imm_src  output  3  extend-unit select: 000 I, 001 S, 010 B, 011 U, 100 J.
REQ-007 alu_src_a  output  2  00 PC, 01 old PC, 10 rs1.
REQ-008 alu_src_b  output  2  00 rs2, 01 imm_ext, 10 constant 4.
REQ-009 alu_op  output  2  00 add, 01 subtract/compare, 10 funct-decoded.
REQ-010 result_src  output  2  00 ALU-out register, 01 read data, 10 ALU result, 11 imm_ext.
REQ-011 adr_src  output  1  memory address select: 0 PC, 1 result.
REQ-012 ir_write, pc_write, reg_write, mem_write  output  1 each  write strobes.
REQ-013 illegal_op  output  1  one-cycle pulse when DECODE sees an unsupported opcode.
REQ-014 instr_done  output  1  one-cycle pulse in the last state of each instruction.
REQ-015 instret  output  32  count of retired instructions.
REQ-016 state  output  4  current FSM state, for debug.

Function
REQ-017 Opcodes SHALL be lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, beq 1100011, jal 1101111, lui 0110111.
REQ-018 imm_src SHALL be combinational from op alone in every state: sw 001, beq 010, lui 011, jal 100, all others 000.
REQ-019 States SHALL be FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, ALUWB 7, EXECI 8, JAL 9, BEQ 10, LUI 11; encodings 12-15 go to FETCH on the next edge.
REQ-020 Transitions SHALL be:
- FETCH->DECODE.
- DECODE->MEMADR for lw/sw, EXECR for R, EXECI for I-ALU, JAL, BEQ, LUI; any other opcode->FETCH.
- MEMADR->MEMREAD for lw, MEMWRITE otherwise.
- MEMREAD->MEMWB.
- EXECR/EXECI/JAL->ALUWB.
- MEMWB, MEMWRITE, ALUWB, BEQ, LUI->FETCH.
REQ-021 Outputs SHALL be Moore decodes of state; any output not listed for a state SHALL be 0.
- FETCH: ir_write=1, adr_src=0, src_a=00, src_b=10, alu_op=00, result_src=10, pc_update=1.
- DECODE: src_a=01, src_b=01, alu_op=00.
- MEMADR: src_a=10, src_b=01, alu_op=00.
- MEMREAD: result_src=00, adr_src=1.
- MEMWRITE: result_src=00, adr_src=1, mem_write=1.
- MEMWB: result_src=01, reg_write=1.
- EXECR: src_a=10, src_b=00, alu_op=10.
- EXECI: src_a=10, src_b=01, alu_op=10.
- ALUWB: result_src=00, reg_write=1.
- JAL: src_a=01, src_b=10, alu_op=00, result_src=00, pc_update=1.
- BEQ: src_a=10, src_b=00, alu_op=01, result_src=00, branch=1.
- LUI: result_src=11, reg_write=1.
REQ-022 pc_write SHALL equal pc_update OR (branch AND zero), combinationally.
REQ-023 illegal_op SHALL be high only in DECODE with an unsupported opcode.
REQ-024 instr_done SHALL be high in MEMWB, MEMWRITE, ALUWB, BEQ and LUI, and also when illegal_op is high.
REQ-025 instret SHALL increment by 1 on each clock edge where instr_done is 1, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-026 Per-instruction latency SHALL be: lw 5, sw 4, R/I/jal 4, beq 3, lui 3, illegal 2 cycles.

Reset
REQ-027 While rst=1, state SHALL be FETCH and instret SHALL be 0.
REQ-028 While rst=1, ir_write, pc_write, reg_write, mem_write, illegal_op and instr_done SHALL be forced to 0.
REQ-029 Reset asserted mid-instruction SHALL abandon that instruction with no further strobes and no instret increment.
REQ-030 The first edge after rst deasserts SHALL move FETCH->DECODE.

Verification
REQ-031 lw: reset release, op=0000011 -> states 0,1,2,3,4,0; reg_write only in MEMWB; adr_src=1 in MEMREAD; instret 0->1.
REQ-032 beq: op=1100011 with zero=1 in BEQ -> pc_write=1 in BEQ; with zero=0 -> pc_write=0; imm_src=010 throughout; latency 3 cycles.
REQ-033 sw then jal: op=0100011 -> mem_write only in MEMWRITE, imm_src=001; op=1101111 -> pc_write in FETCH and JAL, reg_write in ALUWB, imm_src=100.
REQ-034 Illegal opcode: op=1111111 -> illegal_op=1 and instr_done=1 in DECODE, next state FETCH, instret +1, no reg_write or mem_write.
REQ-035 Reset mid-lw: rst asserted in MEMREAD -> state=0 immediately, all strobes 0, instret=0; after release, FETCH->DECODE.
REQ-036 Wrap: force instret to 0xFFFFFFFF, retire lui (op=0110111) -> instret=0; result_src=11 and imm_src=011 in LUI.
